// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one requester's byte at a time to a UART
// transmitter and supervises each transfer with a cycle timeout.
module uart_tx_arbiter #(
    parameter int          NUM_REQ     = 4,
    parameter logic [15:0] TIMEOUT_CYC = 16'd65535
) (
    input  logic                 i_Clock,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic [NUM_REQ-1:0]   o_done,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_active,
    input  logic                 i_tx_done,
    output logic                 o_timeout,
    output logic [1:0]           o_dbg_state
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_ACT  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state;
    logic [IW-1:0] last_winner;
    logic [IW-1:0] cur_idx;
    logic [15:0]   cnt;
    logic          any_req;
    logic [IW-1:0] rr_idx;

    assign o_dbg_state = state;

    // Handshake: requester k holds i_req[k] and its byte until o_ack[k]; the byte
    // is captured with the ack, and o_done[k] follows the transmitter's i_tx_done.
    // The search runs from the farthest offset down so the nearest requester after
    // last_winner is the one left standing.
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        rr_idx  = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = int'(last_winner) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (i_req[IW'(idx)]) begin
                any_req = 1'b1;
                rr_idx  = IW'(idx);
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_reset) begin
            state       <= IDLE;
            o_ack       <= '0;
            o_done      <= '0;
            o_grant     <= '0;
            o_tx_start  <= 1'b0;
            o_tx_data   <= 8'h00;
            o_timeout   <= 1'b0;
            cnt         <= '0;
            cur_idx     <= '0;
            last_winner <= IW'(NUM_REQ - 1);
        end else begin
            o_ack      <= '0;
            o_done     <= '0;
            o_tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req && !i_tx_active) begin
                        o_grant   <= NUM_REQ'(1) << rr_idx;
                        o_ack     <= NUM_REQ'(1) << rr_idx;
                        o_tx_data <= i_req_data[rr_idx*8 +: 8];
                        cur_idx   <= rr_idx;
                        state     <= START;
                    end
                end
                START: begin
                    o_tx_start <= 1'b1;
                    cnt        <= '0;
                    state      <= WAIT_ACT;
                end
                WAIT_ACT, WAIT_DONE: begin
                    cnt <= cnt + 16'd1;
                    // A completion in the same cycle as the deadline still counts as done.
                    if (i_tx_done) begin
                        o_done      <= o_grant;
                        last_winner <= cur_idx;
                        o_grant     <= '0;
                        state       <= IDLE;
                    end else if (cnt == TIMEOUT_CYC - 16'd1) begin
                        o_timeout   <= 1'b1;
                        last_winner <= cur_idx;
                        o_grant     <= '0;
                        state       <= IDLE;
                    end else if (state == WAIT_ACT && i_tx_active) begin
                        state <= WAIT_DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 20;

    logic           i_Clock;
    logic           i_reset;
    logic [N-1:0]   i_req;
    logic [8*N-1:0] i_req_data;
    logic [N-1:0]   o_ack;
    logic [N-1:0]   o_done;
    logic [N-1:0]   o_grant;
    logic           o_tx_start;
    logic [7:0]     o_tx_data;
    logic           i_tx_active;
    logic           i_tx_done;
    logic           o_timeout;
    logic [1:0]     o_dbg_state;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16'(TO))) dut (
        .i_Clock     (i_Clock),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_req_data  (i_req_data),
        .o_ack       (o_ack),
        .o_done      (o_done),
        .o_grant     (o_grant),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .i_tx_active (i_tx_active),
        .i_tx_done   (i_tx_done),
        .o_timeout   (o_timeout),
        .o_dbg_state (o_dbg_state)
    );

    // clock / reset
    initial begin
        i_Clock = 1'b0;
        forever #5 i_Clock = ~i_Clock;
    end

    int n_cmp = 0;
    int n_mis = 0;

    bit rand_req, noise_en, rand_len, rand_rst, tx_stall, force_active;
    int tx_len, tx_cnt;

    // reference model state
    bit           m_valid = 1'b0;
    bit           m_open  = 1'b0;
    int           m_age, m_last, m_owner;
    logic [N-1:0] e_ack, e_done, e_grant;
    logic         e_start, e_timeout;
    logic [7:0]   e_data;
    logic [7:0]   exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: transmitter model, random requesters, random reset.
    task automatic tick();
        @(negedge i_Clock);
        i_tx_done = 1'b0;
        if (force_active) begin
            i_tx_active = 1'b1;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                i_tx_active = 1'b0;
                i_tx_done   = 1'b1;
            end
        end else if (o_tx_start) begin
            int len;
            len = tx_stall ? 0 : tx_len;
            if (rand_len) len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
            tx_cnt      = len;
            i_tx_active = (len > 0);
        end else begin
            i_tx_active = noise_en && ($urandom_range(0, 7) == 0);
            i_tx_done   = noise_en && ($urandom_range(0, 15) == 0);
        end
        if (rand_req) begin
            for (int k = 0; k < N; k++) begin
                if (o_ack[k]) begin
                    if ($urandom_range(0, 1) == 0) i_req[k] = 1'b0;
                    i_req_data[8*k +: 8] = 8'($urandom);
                end else if (!i_req[k] && $urandom_range(0, 5) == 0) begin
                    i_req[k] = 1'b1;
                    i_req_data[8*k +: 8] = 8'($urandom);
                end
            end
        end
        if (rand_rst) i_reset = ($urandom_range(0, 299) == 0);
    endtask

    task automatic wait_ack(input int max, output int lat);
        int n;
        n   = 0;
        lat = -1;
        while (lat < 0 && n < max) begin
            tick();
            n++;
            if (o_ack != '0) lat = n;
        end
    endtask

    task automatic wait_done(input int max, output int lat);
        int n;
        n   = 0;
        lat = -1;
        while (lat < 0 && n < max) begin
            tick();
            n++;
            if (o_done != '0) lat = n;
        end
    endtask

    task automatic restart(input logic [N-1:0] req);
        int n;
        n     = 0;
        i_req = '0;
        while (tx_cnt != 0 && n < 100) begin
            tick();
            n++;
        end
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        i_req   = req;
    endtask

    // Reference model: a transfer opens on arbitration, its start strobe follows one
    // cycle later, and it then has a window of TO cycles to see i_tx_done.
    initial begin : model
        bit found;
        m_last = N - 1; m_age = 0; m_owner = 0;
        e_ack = '0; e_done = '0; e_grant = '0; e_start = 1'b0; e_timeout = 1'b0; e_data = 8'h00;
        forever begin
            @(posedge i_Clock);
            e_ack   = '0;
            e_done  = '0;
            e_start = 1'b0;
            if (i_reset) begin
                m_valid = 1'b1; m_open = 1'b0; m_last = N - 1;
                e_grant = '0; e_data = 8'h00; e_timeout = 1'b0;
                exp_q.delete();
            end else if (m_valid) begin
                if (m_open) begin
                    m_age++;
                    if (m_age == 1) begin
                        e_start = 1'b1;
                    end else if (i_tx_done) begin
                        e_done[m_owner] = 1'b1;
                        m_last = m_owner; m_open = 1'b0; e_grant = '0;
                    end else if (m_age - 2 == TO - 1) begin
                        e_timeout = 1'b1;
                        m_last = m_owner; m_open = 1'b0; e_grant = '0;
                    end
                end else if (i_req != '0 && !i_tx_active) begin
                    found = 1'b0;
                    for (int o = 1; o <= N; o++) begin
                        int k;
                        k = (m_last + o) % N;
                        if (!found && i_req[k]) begin
                            found   = 1'b1;
                            m_owner = k;
                        end
                    end
                    m_open = 1'b1; m_age = 0;
                    e_ack[m_owner] = 1'b1;
                    e_grant = '0;
                    e_grant[m_owner] = 1'b1;
                    e_data = i_req_data[8*m_owner +: 8];
                    exp_q.push_back(e_data);
                end
            end
        end
    end

    // Scoreboard: every cycle after the first reset edge.
    initial begin : compare
        logic [7:0] b;
        forever begin
            @(negedge i_Clock);
            if (m_valid) begin
                check("ack", 16'(o_ack), 16'(e_ack));
                check("done", 16'(o_done), 16'(e_done));
                check("grant", 16'(o_grant), 16'(e_grant));
                check("tx_start", 16'(o_tx_start), 16'(e_start));
                check("tx_data", 16'(o_tx_data), 16'(e_data));
                check("timeout", 16'(o_timeout), 16'(e_timeout));
                check("ack_onehot0", 16'($onehot0(o_ack)), 16'd1);
                check("done_onehot0", 16'($onehot0(o_done)), 16'd1);
                check("grant_onehot0", 16'($onehot0(o_grant)), 16'd1);
                if (e_start) begin
                    check("start_byte_queued", 16'(exp_q.size() > 0), 16'd1);
                    if (exp_q.size() > 0) begin
                        b = exp_q.pop_front();
                        check("start_byte", 16'(o_tx_data), 16'(b));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int lat, n, na, nd, dseen;
        int order[5];
        int dcnt[N];
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        i_reset = 1'b1; i_req = '0; i_req_data = '0; i_tx_active = 1'b0; i_tx_done = 1'b0;
        rand_req = 0; noise_en = 0; rand_len = 0; rand_rst = 0; tx_stall = 0; force_active = 0;
        tx_len = 10; tx_cnt = 0;
        repeat (3) tick();
        check("rst_grant", 16'(o_grant), 16'h0);
        check("rst_ack", 16'(o_ack), 16'h0);
        check("rst_data", 16'(o_tx_data), 16'h0);
        check("rst_timeout", 16'(o_timeout), 16'h0);
        check("rst_state", 16'(o_dbg_state), 16'h0);

        // single request, byte held while its requester changes data
        i_reset = 1'b0;
        i_req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        i_req = 4'b0100;
        wait_ack(10, lat);
        check("t1_ack_lat", 16'(lat), 16'd1);
        check("t1_ack", 16'(o_ack), 16'b0100);
        i_req = '0;
        i_req_data[23:16] = 8'h5A;
        tick();
        check("t1_start", 16'(o_tx_start), 16'd1);
        check("t1_data", 16'(o_tx_data), 16'hA5);
        wait_done(40, lat);
        check("t1_done_lat", 16'(lat), 16'd11);
        check("t1_done", 16'(o_done), 16'b0100);
        check("t1_grant_after", 16'(o_grant), 16'h0);
        check("t1_data_hold", 16'(o_tx_data), 16'hA5);

        // all four requesting continuously
        tx_len = 3;
        restart(4'b1111);
        na = 0; nd = 0; n = 0;
        for (int k = 0; k < N; k++) dcnt[k] = 0;
        while (nd < 8 && n < 200) begin
            tick();
            n++;
            for (int k = 0; k < N; k++) begin
                if (o_ack[k] && na < 5) begin
                    order[na] = k;
                    na++;
                end
                if (o_done[k]) begin
                    dcnt[k]++;
                    nd++;
                end
            end
        end
        check("t2_dones", 16'(nd), 16'd8);
        check("t2_acks", 16'(na), 16'd5);
        for (int i = 0; i < 5; i++) check("t2_order", 16'(order[i]), 16'(exp_order[i]));
        for (int k = 0; k < N; k++) check("t2_done_share", 16'(dcnt[k]), 16'd2);

        // transmitter never completes
        tx_stall = 1;
        restart(4'b0011);
        wait_ack(10, lat);
        check("t3_ack", 16'(o_ack), 16'b0001);
        i_req[0] = 1'b0;
        tick();
        check("t3_start", 16'(o_tx_start), 16'd1);
        n = 0; dseen = 0;
        while (!o_timeout && n < 40) begin
            tick();
            n++;
            if (o_done != '0) dseen++;
        end
        check("t3_timeout_lat", 16'(n), 16'd20);
        check("t3_no_done", 16'(dseen), 16'd0);
        check("t3_grant_clear", 16'(o_grant), 16'h0);
        wait_ack(10, lat);
        check("t3_next_ack", 16'(o_ack), 16'b0010);
        check("t3_timeout_sticky", 16'(o_timeout), 16'd1);
        tx_stall = 0;
        i_req = '0;
        wait_done(40, lat);
        check("t3_next_done", 16'(o_done), 16'b0010);
        check("t3_timeout_sticky2", 16'(o_timeout), 16'd1);

        // transmitter busy in IDLE blocks arbitration
        force_active = 1;
        restart(4'b0001);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_ack_blocked", 16'(o_ack), 16'h0);
        end
        force_active = 0;
        tick();
        check("t4_ack_edge", 16'(o_ack), 16'h0);
        tick();
        check("t4_ack", 16'(o_ack), 16'b0001);
        i_req = '0;
        wait_done(20, lat);
        check("t4_done", 16'(o_done), 16'b0001);

        // reset in the middle of a transfer
        tx_len = 10;
        restart(4'b0011);
        wait_ack(10, lat);
        check("t5_ack", 16'(o_ack), 16'b0001);
        repeat (5) tick();
        check("t5_state_wait_done", 16'(o_dbg_state), 16'd3);
        i_reset = 1'b1;
        tick();
        check("t5_rst_grant", 16'(o_grant), 16'h0);
        check("t5_rst_ack", 16'(o_ack), 16'h0);
        check("t5_rst_done", 16'(o_done), 16'h0);
        check("t5_rst_start", 16'(o_tx_start), 16'h0);
        check("t5_rst_data", 16'(o_tx_data), 16'h0);
        check("t5_rst_timeout", 16'(o_timeout), 16'h0);
        i_reset = 1'b0;
        n = 0; dseen = 0; lat = -1;
        while (lat < 0 && n < 30) begin
            tick();
            n++;
            if (o_done != '0) dseen++;
            if (o_ack != '0) lat = n;
        end
        check("t5_no_done", 16'(dseen), 16'd0);
        check("t5_first_ack", 16'(o_ack), 16'b0001);
        i_req = '0;

        // randomized traffic against the model
        restart(4'b0000);
        rand_req = 1; noise_en = 1; rand_len = 1; rand_rst = 1;
        repeat (4000) tick();
        rand_req = 0; noise_en = 0; rand_len = 0; rand_rst = 0;
        i_reset = 1'b0;
        i_req = '0;
        repeat (60) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
